vga_pattern_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 45 ++++
 rtl/vga_box_mover.sv | 59 +++++
 rtl/vga_pattern_gen.sv | 108 ++++++++++
 tb/tb_vga_pattern_gen.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern generator: default timing bounds,
// RGB332 colour constants, pattern-mode encodings and the colour-bar lookup.
package vga_pkg;

    localparam int H_LAST      = 799;
    localparam int V_LAST      = 520;
    localparam int H_VIS_START = 144;
    localparam int H_VIS_END   = 783;
    localparam int V_VIS_START = 32;
    localparam int V_VIS_END   = 510;

    // Width of one colour bar in pixels (eight bars across 640 columns).
    localparam int BAR_W = 80;

    localparam logic [7:0] WHITE   = 8'hFF;
    localparam logic [7:0] YELLOW  = 8'hFC;
    localparam logic [7:0] CYAN    = 8'h1F;
    localparam logic [7:0] GREEN   = 8'h1C;
    localparam logic [7:0] MAGENTA = 8'hE3;
    localparam logic [7:0] RED     = 8'hE0;
    localparam logic [7:0] BLUE    = 8'h03;
    localparam logic [7:0] BLACK   = 8'h00;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_CHECK = 2'd1,
        MODE_BOX   = 2'd2,
        MODE_EXT   = 2'd3
    } mode_e;

    // Bar colour for visible column x; a compare chain stands in for x/80.
    function automatic logic [7:0] bar_color(input logic [9:0] x);
        logic [7:0] c;
        if      (x < 10'(1 * BAR_W)) c = WHITE;
        else if (x < 10'(2 * BAR_W)) c = YELLOW;
        else if (x < 10'(3 * BAR_W)) c = CYAN;
        else if (x < 10'(4 * BAR_W)) c = GREEN;
        else if (x < 10'(5 * BAR_W)) c = MAGENTA;
        else if (x < 10'(6 * BAR_W)) c = RED;
        else if (x < 10'(7 * BAR_W)) c = BLUE;
        else                         c = BLACK;
        return c;
    endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position registers.
//   dclk, rst_n : pixel clock, async active-low reset
//   en          : one-cycle update strobe (frame end and not frozen)
//   box_x/box_y : top-left corner of the box in visible coordinates
// Each axis moves by STEP per update and reflects at 0 and at its limit.
module vga_box_mover
    import vga_pkg::*;
#(
    parameter int STEP    = 2,
    parameter int X_LIMIT = 608,
    parameter int Y_LIMIT = 447
) (
    input  logic       dclk,
    input  logic       rst_n,
    input  logic       en,
    output logic [9:0] box_x,
    output logic [9:0] box_y
);

    logic       dir_x_neg, dir_y_neg;
    logic [9:0] nxt_x, nxt_y;
    logic       nxt_dx, nxt_dy;

    // Returns {new_dir_neg, new_pos}. Limits are tested before the add or
    // subtract is applied, so the position never wraps below zero.
    function automatic logic [10:0] step_axis(input logic [9:0] pos,
                                              input logic       neg,
                                              input logic [9:0] lim);
        logic [10:0] r;
        if (!neg) begin
            if (({1'b0, pos} + 11'(STEP)) >= {1'b0, lim}) r = {1'b1, lim};
            else                                          r = {1'b0, pos + 10'(STEP)};
        end else begin
            if (pos <= 10'(STEP)) r = {1'b0, 10'd0};
            else                  r = {1'b1, pos - 10'(STEP)};
        end
        return r;
    endfunction

    always_comb begin
        {nxt_dx, nxt_x} = step_axis(box_x, dir_x_neg, 10'(X_LIMIT));
        {nxt_dy, nxt_y} = step_axis(box_y, dir_y_neg, 10'(Y_LIMIT));
    end

    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            box_x     <= '0;
            box_y     <= '0;
            dir_x_neg <= 1'b0;
            dir_y_neg <= 1'b0;
        end else if (en) begin
            box_x     <= nxt_x;
            box_y     <= nxt_y;
            dir_x_neg <= nxt_dx;
            dir_y_neg <= nxt_dy;
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source running in lockstep with the VGA output stage.
//   dclk, rst_n : pixel clock, async active-low reset
//   mode        : pattern select (bars, checker, box, external)
//   ext_data    : external pixel used in external mode
//   freeze      : holds the box position while high
//   data        : registered RGB332 pixel for the output stage's position
//   frame_tick  : one-dclk pulse after the last line of each frame
// data is computed one position ahead, so once registered it lines up with
// the output stage's counters.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int         H_LAST      = vga_pkg::H_LAST,
    parameter int         V_LAST      = vga_pkg::V_LAST,
    parameter int         H_VIS_START = vga_pkg::H_VIS_START,
    parameter int         H_VIS_END   = vga_pkg::H_VIS_END,
    parameter int         V_VIS_START = vga_pkg::V_VIS_START,
    parameter int         V_VIS_END   = vga_pkg::V_VIS_END,
    parameter int         BOX_SIZE    = 32,
    parameter int         STEP        = 2,
    parameter logic [7:0] BOX_COLOR   = 8'hE0,
    parameter logic [7:0] BG_COLOR    = 8'h03
) (
    input  logic       dclk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic [7:0] ext_data,
    input  logic       freeze,
    output logic [7:0] data,
    output logic       frame_tick
);

    localparam int X_LIMIT = H_VIS_END - H_VIS_START + 1 - BOX_SIZE;
    localparam int Y_LIMIT = V_VIS_END - V_VIS_START + 1 - BOX_SIZE;

    logic [9:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic [9:0] x, y, box_x, box_y;
    logic       frame_end, vis, in_box;
    logic [7:0] pix;
    mode_e      mode_q;

    // The last line is a single dclk: the count returns to (0,0) straight
    // from (0,V_LAST), without waiting for the horizontal wrap.
    always_comb begin
        h_nxt = h_cnt + 10'd1;
        v_nxt = v_cnt;
        if (v_cnt == 10'(V_LAST)) begin
            h_nxt = '0;
            v_nxt = '0;
        end else if (h_cnt == 10'(H_LAST)) begin
            h_nxt = '0;
            v_nxt = v_cnt + 10'd1;
        end
    end

    assign frame_end = (v_cnt == 10'(V_LAST));

    assign vis = (h_nxt >= 10'(H_VIS_START)) && (h_nxt <= 10'(H_VIS_END)) &&
                 (v_nxt >= 10'(V_VIS_START)) && (v_nxt <= 10'(V_VIS_END));
    assign x = h_nxt - 10'(H_VIS_START);
    assign y = v_nxt - 10'(V_VIS_START);

    assign in_box = (x >= box_x) && ({1'b0, x} <= ({1'b0, box_x} + 11'(BOX_SIZE - 1))) &&
                    (y >= box_y) && ({1'b0, y} <= ({1'b0, box_y} + 11'(BOX_SIZE - 1)));

    always_comb begin
        pix = BLACK;
        if (vis) begin
            case (mode_q)
                MODE_BARS:  pix = bar_color(x);
                MODE_CHECK: pix = (x[5] ^ y[5]) ? WHITE : BLACK;
                MODE_BOX:   pix = in_box ? BOX_COLOR : BG_COLOR;
                default:    pix = ext_data;
            endcase
        end
    end

    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt      <= '0;
            v_cnt      <= '0;
            data       <= 8'h00;
            frame_tick <= 1'b0;
            mode_q     <= MODE_BARS;
        end else begin
            h_cnt      <= h_nxt;
            v_cnt      <= v_nxt;
            data       <= pix;
            frame_tick <= frame_end;
            // Mode is only taken at the frame origin so a frame never mixes patterns.
            if (h_nxt == '0 && v_nxt == '0)
                mode_q <= mode_e'(mode);
        end
    end

    vga_box_mover #(
        .STEP    (STEP),
        .X_LIMIT (X_LIMIT),
        .Y_LIMIT (Y_LIMIT)
    ) u_box (
        .dclk  (dclk),
        .rst_n (rst_n),
        .en    (frame_end & ~freeze),
        .box_x (box_x),
        .box_y (box_y)
    );

endmodule

// File: tb/tb_vga_pattern_gen.sv
module tb_vga_pattern_gen;

    // Full-width lines, short frames so many frame-level events fit in a run.
    localparam int HL = 799, HVS = 144, HVE = 783;
    localparam int VL = 6, VVS = 1, VVE = 5;
    localparam int BOX = 3, STP = 160;
    localparam int XL = (HVE - HVS + 1) - BOX;   // 637
    localparam int YL = (VVE - VVS + 1) - BOX;   // 2
    localparam int FRAME_LEN = VL * (HL + 1) + 1;

    logic       dclk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] ext_data = 8'h00;
    logic       freeze = 1'b0;
    logic [7:0] data;
    logic       frame_tick;

    vga_pattern_gen #(
        .H_LAST(HL), .V_LAST(VL), .H_VIS_START(HVS), .H_VIS_END(HVE),
        .V_VIS_START(VVS), .V_VIS_END(VVE), .BOX_SIZE(BOX), .STEP(STP),
        .BOX_COLOR(8'hE0), .BG_COLOR(8'h03)
    ) dut (
        .dclk(dclk), .rst_n(rst_n), .mode(mode), .ext_data(ext_data),
        .freeze(freeze), .data(data), .frame_tick(frame_tick)
    );

    always #20 dclk = ~dclk;

    int n_assert = 0, n_fail = 0;

    // Reference model state: output-stage position, latched mode, box.
    int hm, vm, mode_m, bx, by, cyc, last_tick, ticks;
    bit dxp, dyp, tick_exp;
    logic [7:0] ext_s, exp_data;
    logic [7:0] bars [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] colour(int h, int v);
        int x, y;
        if (h < HVS || h > HVE || v < VVS || v > VVE) return 8'h00;
        x = h - HVS;
        y = v - VVS;
        case (mode_m)
            0: return bars[x / 80];
            1: return (((x / 32) % 2) != ((y / 32) % 2)) ? 8'hFF : 8'h00;
            2: return (x >= bx && x < bx + BOX && y >= by && y < by + BOX) ? 8'hE0 : 8'h03;
            default: return ext_s;
        endcase
    endfunction

    task automatic model_reset();
        hm = 0; vm = 0; mode_m = 0; bx = 0; by = 0; dxp = 1; dyp = 1;
        cyc = 0; last_tick = 0;
    endtask

    task automatic move_box();
        if (dxp) begin
            if (bx + STP >= XL) begin bx = XL; dxp = 0; end else bx = bx + STP;
        end else begin
            if (bx <= STP) begin bx = 0; dxp = 1; end else bx = bx - STP;
        end
        if (dyp) begin
            if (by + STP >= YL) begin by = YL; dyp = 0; end else by = by + STP;
        end else begin
            if (by <= STP) begin by = 0; dyp = 1; end else by = by - STP;
        end
    endtask

    // One dclk: advance the model with the inputs seen at the edge, then
    // compare the DUT on the falling edge.
    task automatic cycle();
        @(posedge dclk);
        ext_s = ext_data;
        tick_exp = (vm == VL);
        if (vm == VL) begin
            if (!freeze) move_box();
            hm = 0; vm = 0;
        end else begin
            hm++;
            if (hm > HL) begin hm = 0; vm++; end
        end
        if (hm == 0 && vm == 0) mode_m = int'(mode);
        exp_data = colour(hm, vm);
        cyc++;
        @(negedge dclk);
        chk($sformatf("data m%0d h%0d v%0d", mode_m, hm, vm), 32'(data), 32'(exp_data));
        chk($sformatf("tick h%0d v%0d", hm, vm), 32'(frame_tick), 32'(tick_exp));
        if (frame_tick === 1'b1) begin
            chk("tick_period", 32'(cyc - last_tick), 32'(FRAME_LEN));
            last_tick = cyc;
            ticks++;
        end
        ext_data = 8'($urandom);
    endtask

    task automatic run_frame(input logic [1:0] next_mode, input logic frz);
        int g1, g2;
        g1 = $urandom_range(1, FRAME_LEN / 2);
        g2 = $urandom_range(FRAME_LEN / 2 + 1, FRAME_LEN - 2);
        freeze = frz;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (i == g1) mode = 2'($urandom_range(0, 3));
            if (i == g2) mode = next_mode;
            cycle();
        end
    endtask

    initial begin
        int target, guard;
        ticks = 0;
        model_reset();
        repeat (3) @(negedge dclk);
        chk("reset data", 32'(data), 32'h00);
        chk("reset tick", 32'(frame_tick), 32'h0);
        rst_n = 1'b1;
        model_reset();

        run_frame(2'd1, 1'b0);                 // bars
        run_frame(2'd2, 1'b0);                 // checker
        for (int f = 2; f < 12; f++)           // box, frozen over three updates
            run_frame((f == 11) ? 2'd3 : 2'd2, (f >= 5 && f <= 7));
        run_frame(2'd0, 1'b0);                 // external
        chk("tick count", 32'(ticks), 32'd13);

        // Reset partway through a visible bar line.
        target = $urandom_range(HVS, HVS + 400);
        guard = 0;
        while (!(vm == 3 && hm == target) && guard < FRAME_LEN) begin
            cycle();
            guard++;
        end
        chk("reach reset point", 32'(guard < FRAME_LEN), 32'd1);
        #5 rst_n = 1'b0;
        #1;
        chk("async reset data", 32'(data), 32'h00);
        chk("async reset tick", 32'(frame_tick), 32'h0);
        @(posedge dclk);
        @(negedge dclk);
        chk("held reset data", 32'(data), 32'h00);
        rst_n = 1'b1;
        model_reset();
        ticks = 0;
        mode = 2'd2;
        freeze = 1'b0;
        for (int i = 0; i < 2 * FRAME_LEN; i++) cycle();
        chk("ticks after reset", 32'(ticks), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
